// File: rtl/k423_if_bpu_upd_queue.sv
// In-order queue of in-flight branch predictions; pops on EX resolve and drives
// the predictor update port one cycle later with the next saturating-counter value.
`ifndef CORE_ADDR_W
`define CORE_ADDR_W 32
`endif

module k423_if_bpu_upd_queue #(
   parameter int DEPTH  = 4,
   parameter int ADDR_W = `CORE_ADDR_W
) (
   input  logic                       clk_i,
   input  logic                       rst_n_i,
   input  logic                       flush_i,
   input  logic                       prd_vld_i,
   output logic                       prd_rdy_o,
   input  logic [ADDR_W-1:0]          prd_pc_i,
   input  logic                       prd_tkn_i,
   input  logic [1:0]                 prd_sat_cnt_i,
   input  logic                       rsv_vld_i,
   input  logic                       rsv_tkn_i,
   input  logic [ADDR_W-1:0]          rsv_pc_i,
   output logic                       upd_vld_o,
   output logic                       upd_tkn_o,
   output logic [ADDR_W-1:0]          upd_src_pc_o,
   output logic [1:0]                 upd_sat_cnt_o,
   output logic                       mispred_o,
   output logic                       pc_err_o,
   output logic [$clog2(DEPTH):0]     cnt_o
);

   localparam int AW = $clog2(DEPTH);
   localparam int PW = AW + 1;

   // Handshake: a push transfers on a clock edge where prd_vld_i && prd_rdy_o;
   // prd_rdy_o depends only on registered pointers, never on same-cycle inputs.

   logic [ADDR_W-1:0] mem_pc  [DEPTH];
   logic              mem_tkn [DEPTH];
   logic [1:0]        mem_sat [DEPTH];

   logic [PW-1:0]     wr_ptr;
   logic [PW-1:0]     rd_ptr;
   logic              full;
   logic              empty;
   logic [ADDR_W-1:0] head_pc;
   logic              head_tkn;
   logic [1:0]        head_sat;
   logic              hit;
   logic              mis;
   logic              push;

   function automatic logic [1:0] sat_next(input logic [1:0] sat, input logic tkn);
      logic [1:0] res;
      res = sat;
      if (tkn) begin
         if (sat != 2'b11) res = sat + 2'd1;
      end else begin
         if (sat != 2'b00) res = sat - 2'd1;
      end
      return res;
   endfunction

   always_comb begin
      full      = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
      empty     = (wr_ptr == rd_ptr);
      head_pc   = mem_pc[rd_ptr[AW-1:0]];
      head_tkn  = mem_tkn[rd_ptr[AW-1:0]];
      head_sat  = mem_sat[rd_ptr[AW-1:0]];
      hit       = rsv_vld_i && !empty && (rsv_pc_i == head_pc);
      mis       = hit && (rsv_tkn_i != head_tkn);
      // Flush and mispredict both squash younger work, so a same-cycle push is dropped.
      push      = prd_vld_i && !full && !flush_i && !mis;
      prd_rdy_o = !full;
      cnt_o     = wr_ptr - rd_ptr;
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PW'(1);
         if (flush_i || mis) rd_ptr <= wr_ptr;
         else if (hit)       rd_ptr <= rd_ptr + PW'(1);
      end
   end

   always_ff @(posedge clk_i) begin
      if (push) begin
         mem_pc[wr_ptr[AW-1:0]]  <= prd_pc_i;
         mem_tkn[wr_ptr[AW-1:0]] <= prd_tkn_i;
         mem_sat[wr_ptr[AW-1:0]] <= prd_sat_cnt_i;
      end
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         upd_vld_o     <= 1'b0;
         upd_tkn_o     <= 1'b0;
         upd_src_pc_o  <= '0;
         upd_sat_cnt_o <= 2'b00;
         mispred_o     <= 1'b0;
         pc_err_o      <= 1'b0;
      end else begin
         upd_vld_o <= hit;
         mispred_o <= mis;
         pc_err_o  <= rsv_vld_i && !hit;
         if (hit) begin
            upd_tkn_o     <= rsv_tkn_i;
            upd_src_pc_o  <= head_pc;
            upd_sat_cnt_o <= sat_next(head_sat, rsv_tkn_i);
         end
      end
   end

endmodule

// File: tb/tb_k423_if_bpu_upd_queue.sv
// Self-checking bench for k423_if_bpu_upd_queue: directed scenarios plus a
// randomized run checked against a queue-based reference model.
module tb_k423_if_bpu_upd_queue;

   localparam int DEPTH = 4;
   localparam int AW    = 32;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          flush = 1'b0;
   logic          prd_vld = 1'b0;
   logic          prd_rdy;
   logic [AW-1:0] prd_pc = '0;
   logic          prd_tkn = 1'b0;
   logic [1:0]    prd_sat = 2'b00;
   logic          rsv_vld = 1'b0;
   logic          rsv_tkn = 1'b0;
   logic [AW-1:0] rsv_pc = '0;
   logic          upd_vld;
   logic          upd_tkn;
   logic [AW-1:0] upd_pc;
   logic [1:0]    upd_sat;
   logic          mispred;
   logic          pc_err;
   logic [2:0]    cnt;

   int n_cmp  = 0;
   int n_fail = 0;

   typedef struct {
      logic [AW-1:0] pc;
      logic          tkn;
      logic [1:0]    sat;
   } ent_t;
   ent_t mq[$];

   logic          exp_vld, exp_tkn, exp_mis, exp_err, exp_rdy_pre, obs_rdy_pre;
   logic [AW-1:0] exp_pc;
   logic [1:0]    exp_sat;

   k423_if_bpu_upd_queue #(.DEPTH(DEPTH), .ADDR_W(AW)) dut (
      .clk_i(clk), .rst_n_i(rst_n), .flush_i(flush),
      .prd_vld_i(prd_vld), .prd_rdy_o(prd_rdy), .prd_pc_i(prd_pc),
      .prd_tkn_i(prd_tkn), .prd_sat_cnt_i(prd_sat),
      .rsv_vld_i(rsv_vld), .rsv_tkn_i(rsv_tkn), .rsv_pc_i(rsv_pc),
      .upd_vld_o(upd_vld), .upd_tkn_o(upd_tkn), .upd_src_pc_o(upd_pc),
      .upd_sat_cnt_o(upd_sat), .mispred_o(mispred), .pc_err_o(pc_err),
      .cnt_o(cnt)
   );

   always #5 clk = ~clk;

   // Saturating 2-bit counter written as clamped integer arithmetic.
   function automatic logic [1:0] ref_next(input logic [1:0] sat, input logic tkn);
      int v;
      v = int'(sat) + (tkn ? 1 : -1);
      if (v > 3) v = 3;
      if (v < 0) v = 0;
      return v[1:0];
   endfunction

   // One clock of stimulus; the model predicts what the DUT shows after the edge.
   task automatic drive_cycle(input logic pv, input logic [AW-1:0] ppc, input logic ptkn,
                              input logic [1:0] psat, input logic rv, input logic rtkn,
                              input logic [AW-1:0] rpc, input logic fl);
      ent_t e;
      logic hit, mis, acc;
      acc         = pv && (mq.size() < DEPTH);
      hit         = rv && (mq.size() > 0) && (mq[0].pc == rpc);
      mis         = hit && (mq[0].tkn != rtkn);
      exp_vld     = hit;
      exp_err     = rv && !hit;
      exp_mis     = mis;
      exp_rdy_pre = (mq.size() < DEPTH);
      if (hit) begin
         exp_tkn = rtkn;
         exp_pc  = mq[0].pc;
         exp_sat = ref_next(mq[0].sat, rtkn);
      end
      prd_vld = pv; prd_pc = ppc; prd_tkn = ptkn; prd_sat = psat;
      rsv_vld = rv; rsv_tkn = rtkn; rsv_pc = rpc; flush = fl;
      obs_rdy_pre = prd_rdy;
      if (hit) void'(mq.pop_front());
      if (fl || mis) mq.delete();
      else if (acc) begin
         e.pc = ppc; e.tkn = ptkn; e.sat = psat;
         mq.push_back(e);
      end
      @(posedge clk); #1;
      prd_vld = 1'b0; rsv_vld = 1'b0; flush = 1'b0;
   endtask

   task automatic idle_cycle();
      drive_cycle(1'b0, '0, 1'b0, 2'b00, 1'b0, 1'b0, '0, 1'b0);
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      mq.delete();
      repeat (2) @(posedge clk);
      #1;
      n_cmp++;
      if ({upd_vld, upd_tkn, upd_pc, upd_sat, mispred, pc_err} !== '0) begin
         n_fail++; $display("FAIL reset_outs: got %0h required 0", {upd_vld, upd_tkn, upd_pc, upd_sat, mispred, pc_err});
      end
      n_cmp++;
      if (cnt !== 3'd0 || prd_rdy !== 1'b1) begin
         n_fail++; $display("FAIL reset_cnt_rdy: got cnt=%0d rdy=%b required 0/1", cnt, prd_rdy);
      end
      rst_n = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic test_basic_taken();
      drive_cycle(1'b1, 32'h100, 1'b1, 2'b10, 1'b0, 1'b0, '0, 1'b0);
      n_cmp++;
      if (cnt !== 3'd1) begin n_fail++; $display("FAIL basic_push_cnt: got %0d required 1", cnt); end
      drive_cycle(1'b0, '0, 1'b0, 2'b00, 1'b1, 1'b1, 32'h100, 1'b0);
      n_cmp++;
      if (upd_vld !== 1'b1 || upd_pc !== 32'h100 || upd_sat !== 2'b11 || upd_tkn !== 1'b1 || mispred !== 1'b0) begin
         n_fail++; $display("FAIL basic_update: got vld=%b pc=%h sat=%b tkn=%b mis=%b required 1/100/11/1/0",
                            upd_vld, upd_pc, upd_sat, upd_tkn, mispred);
      end
      n_cmp++;
      if (cnt !== 3'd0) begin n_fail++; $display("FAIL basic_pop_cnt: got %0d required 0", cnt); end
      idle_cycle();
      n_cmp++;
      if (upd_vld !== 1'b0) begin n_fail++; $display("FAIL basic_pulse: got upd_vld=%b required 0", upd_vld); end
   endtask

   task automatic test_saturate();
      drive_cycle(1'b1, 32'h200, 1'b0, 2'b00, 1'b0, 1'b0, '0, 1'b0);
      drive_cycle(1'b0, '0, 1'b0, 2'b00, 1'b1, 1'b0, 32'h200, 1'b0);
      n_cmp++;
      if (upd_vld !== 1'b1 || upd_sat !== 2'b00 || mispred !== 1'b0) begin
         n_fail++; $display("FAIL sat_low: got vld=%b sat=%b mis=%b required 1/00/0", upd_vld, upd_sat, mispred);
      end
      drive_cycle(1'b1, 32'h204, 1'b1, 2'b11, 1'b0, 1'b0, '0, 1'b0);
      drive_cycle(1'b0, '0, 1'b0, 2'b00, 1'b1, 1'b1, 32'h204, 1'b0);
      n_cmp++;
      if (upd_vld !== 1'b1 || upd_sat !== 2'b11 || upd_pc !== 32'h204) begin
         n_fail++; $display("FAIL sat_high: got vld=%b sat=%b pc=%h required 1/11/204", upd_vld, upd_sat, upd_pc);
      end
   endtask

   task automatic test_mispredict();
      drive_cycle(1'b1, 32'h300, 1'b0, 2'b01, 1'b0, 1'b0, '0, 1'b0);
      drive_cycle(1'b1, 32'h304, 1'b1, 2'b10, 1'b0, 1'b0, '0, 1'b0);
      drive_cycle(1'b1, 32'h308, 1'b1, 2'b10, 1'b0, 1'b0, '0, 1'b0);
      n_cmp++;
      if (cnt !== 3'd3) begin n_fail++; $display("FAIL mis_fill_cnt: got %0d required 3", cnt); end
      drive_cycle(1'b1, 32'h30c, 1'b1, 2'b10, 1'b1, 1'b1, 32'h300, 1'b0);
      n_cmp++;
      if (upd_vld !== 1'b1 || upd_sat !== 2'b10 || mispred !== 1'b1 || upd_pc !== 32'h300) begin
         n_fail++; $display("FAIL mis_update: got vld=%b sat=%b mis=%b pc=%h required 1/10/1/300",
                            upd_vld, upd_sat, mispred, upd_pc);
      end
      n_cmp++;
      if (cnt !== 3'd0) begin n_fail++; $display("FAIL mis_discard_cnt: got %0d required 0", cnt); end
      idle_cycle();
      n_cmp++;
      if (mispred !== 1'b0) begin n_fail++; $display("FAIL mis_pulse: got %b required 0", mispred); end
   endtask

   task automatic test_full();
      for (int i = 0; i < DEPTH; i++)
         drive_cycle(1'b1, 32'h600 + 32'(4 * i), 1'b1, 2'b01, 1'b0, 1'b0, '0, 1'b0);
      n_cmp++;
      if (prd_rdy !== 1'b0 || cnt !== 3'd4) begin
         n_fail++; $display("FAIL full_state: got rdy=%b cnt=%0d required 0/4", prd_rdy, cnt);
      end
      drive_cycle(1'b1, 32'h700, 1'b1, 2'b01, 1'b1, 1'b1, 32'h600, 1'b0);
      n_cmp++;
      if (cnt !== 3'd3 || prd_rdy !== 1'b1 || upd_vld !== 1'b1) begin
         n_fail++; $display("FAIL full_push_pop: got cnt=%0d rdy=%b vld=%b required 3/1/1", cnt, prd_rdy, upd_vld);
      end
      for (int i = 1; i < DEPTH; i++) begin
         drive_cycle(1'b0, '0, 1'b0, 2'b00, 1'b1, 1'b1, 32'h600 + 32'(4 * i), 1'b0);
         n_cmp++;
         if (upd_vld !== 1'b1 || upd_pc !== 32'h600 + 32'(4 * i)) begin
            n_fail++; $display("FAIL full_drain_%0d: got vld=%b pc=%h required 1/%h", i, upd_vld, upd_pc, 32'h600 + 32'(4 * i));
         end
      end
   endtask

   task automatic test_pc_err();
      drive_cycle(1'b0, '0, 1'b0, 2'b00, 1'b1, 1'b1, 32'h400, 1'b0);
      n_cmp++;
      if (pc_err !== 1'b1 || upd_vld !== 1'b0) begin
         n_fail++; $display("FAIL err_empty: got err=%b vld=%b required 1/0", pc_err, upd_vld);
      end
      drive_cycle(1'b1, 32'h400, 1'b1, 2'b10, 1'b0, 1'b0, '0, 1'b0);
      n_cmp++;
      if (pc_err !== 1'b0) begin n_fail++; $display("FAIL err_pulse: got %b required 0", pc_err); end
      drive_cycle(1'b0, '0, 1'b0, 2'b00, 1'b1, 1'b1, 32'h500, 1'b0);
      n_cmp++;
      if (pc_err !== 1'b1 || upd_vld !== 1'b0 || cnt !== 3'd1) begin
         n_fail++; $display("FAIL err_mismatch: got err=%b vld=%b cnt=%0d required 1/0/1", pc_err, upd_vld, cnt);
      end
      drive_cycle(1'b0, '0, 1'b0, 2'b00, 1'b1, 1'b1, 32'h400, 1'b0);
      n_cmp++;
      if (upd_vld !== 1'b1 || upd_pc !== 32'h400 || pc_err !== 1'b0) begin
         n_fail++; $display("FAIL err_retained: got vld=%b pc=%h err=%b required 1/400/0", upd_vld, upd_pc, pc_err);
      end
   endtask

   task automatic test_wrap();
      drive_cycle(1'b1, 32'h1000, 1'b1, 2'($urandom_range(0, 3)), 1'b0, 1'b0, '0, 1'b0);
      for (int i = 1; i <= 10; i++) begin
         drive_cycle(i < 10, 32'h1000 + 32'(4 * i), 1'b1, 2'($urandom_range(0, 3)),
                     1'b1, 1'b1, 32'h1000 + 32'(4 * (i - 1)), 1'b0);
         n_cmp++;
         if (upd_vld !== 1'b1 || upd_pc !== 32'h1000 + 32'(4 * (i - 1)) || upd_sat !== exp_sat) begin
            n_fail++; $display("FAIL wrap_%0d: got vld=%b pc=%h sat=%b required 1/%h/%b",
                               i, upd_vld, upd_pc, upd_sat, 32'h1000 + 32'(4 * (i - 1)), exp_sat);
         end
         n_cmp++;
         if (cnt !== ((i < 10) ? 3'd1 : 3'd0)) begin n_fail++; $display("FAIL wrap_cnt_%0d: got %0d", i, cnt); end
      end
   endtask

   task automatic test_flush();
      drive_cycle(1'b1, 32'h800, 1'b1, 2'b01, 1'b0, 1'b0, '0, 1'b0);
      drive_cycle(1'b1, 32'h804, 1'b1, 2'b01, 1'b0, 1'b0, '0, 1'b0);
      drive_cycle(1'b1, 32'h808, 1'b1, 2'b01, 1'b1, 1'b1, 32'h800, 1'b1);
      n_cmp++;
      if (upd_vld !== 1'b1 || upd_pc !== 32'h800 || upd_sat !== 2'b10 || cnt !== 3'd0) begin
         n_fail++; $display("FAIL flush_pop: got vld=%b pc=%h sat=%b cnt=%0d required 1/800/10/0",
                            upd_vld, upd_pc, upd_sat, cnt);
      end
      idle_cycle();
      n_cmp++;
      if (upd_vld !== 1'b0 || cnt !== 3'd0) begin
         n_fail++; $display("FAIL flush_after: got vld=%b cnt=%0d required 0/0", upd_vld, cnt);
      end
   endtask

   task automatic test_random();
      logic pv, rv, rt, fl;
      logic [AW-1:0] rp, pp;
      for (int i = 0; i < 300; i++) begin
         pv = ($urandom_range(0, 3) != 0);
         rv = ($urandom_range(0, 2) != 0);
         pp = 32'h2000 + 32'($urandom_range(0, 63) * 4);
         rp = (mq.size() > 0 && $urandom_range(0, 5) != 0) ? mq[0].pc : 32'h2000 + 32'($urandom_range(0, 63) * 4);
         rt = (mq.size() > 0 && $urandom_range(0, 4) != 0) ? mq[0].tkn : 1'($urandom_range(0, 1));
         fl = ($urandom_range(0, 19) == 0);
         drive_cycle(pv, pp, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), rv, rt, rp, fl);
         n_cmp++;
         if (obs_rdy_pre !== exp_rdy_pre) begin
            n_fail++; $display("FAIL rnd_rdy_%0d: got %b required %b", i, obs_rdy_pre, exp_rdy_pre);
         end
         n_cmp++;
         if (upd_vld !== exp_vld || mispred !== exp_mis || pc_err !== exp_err) begin
            n_fail++; $display("FAIL rnd_strobes_%0d: got vld=%b mis=%b err=%b required %b/%b/%b",
                               i, upd_vld, mispred, pc_err, exp_vld, exp_mis, exp_err);
         end
         if (exp_vld) begin
            n_cmp++;
            if (upd_pc !== exp_pc || upd_tkn !== exp_tkn || upd_sat !== exp_sat) begin
               n_fail++; $display("FAIL rnd_data_%0d: got pc=%h tkn=%b sat=%b required %h/%b/%b",
                                  i, upd_pc, upd_tkn, upd_sat, exp_pc, exp_tkn, exp_sat);
            end
         end
         n_cmp++;
         if (int'(cnt) != mq.size()) begin
            n_fail++; $display("FAIL rnd_cnt_%0d: got %0d required %0d", i, cnt, mq.size());
         end
      end
   endtask

   task automatic test_reset_midstream();
      drive_cycle(1'b1, 32'h900, 1'b1, 2'b01, 1'b0, 1'b0, '0, 1'b0);
      drive_cycle(1'b1, 32'h904, 1'b1, 2'b01, 1'b1, 1'b0, 32'h900, 1'b0);
      #2;
      rst_n = 1'b0;
      mq.delete();
      #1;
      n_cmp++;
      if ({upd_vld, upd_tkn, upd_pc, upd_sat, mispred, pc_err} !== '0 || cnt !== 3'd0 || prd_rdy !== 1'b1) begin
         n_fail++; $display("FAIL reset_mid: got outs=%0h cnt=%0d rdy=%b required 0/0/1",
                            {upd_vld, upd_tkn, upd_pc, upd_sat, mispred, pc_err}, cnt, prd_rdy);
      end
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
      n_cmp++;
      if (upd_vld !== 1'b0 || cnt !== 3'd0) begin
         n_fail++; $display("FAIL reset_release: got vld=%b cnt=%0d required 0/0", upd_vld, cnt);
      end
   endtask

   initial begin
      test_reset();
      test_basic_taken();
      test_saturate();
      test_mispredict();
      test_full();
      test_pc_err();
      test_wrap();
      test_flush();
      test_random();
      test_reset_midstream();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
